sys_bus_arbiter: RTL and testbench

- Two-master arbiter that shares the single system-memory port between the instruction cache (read-only line fills) and the data cache (line fills and write-through stores).
- Sits between the two cache controllers' Sys* interfaces and the memory/bus model.
- Holds one grant for the whole transaction, from strobe until memory Ready. Forwards per-word Ack and final Ready only to the granted master.

---
 rtl/sys_bus_arbiter.sv | 131 +++++++++++++
 tb/tb_sys_bus_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_bus_arbiter.sv
// Two-master (icache/dcache) arbiter for the shared system-memory port, grant held from strobe to MReady.
// Optional macro SYS_ARB_ROUND_ROBIN_EN: alternate ties via last_grant; default build gives dcache fixed priority.
module sys_bus_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          IStrobe,
    input  logic [AW-1:0] IAddress,
    output logic [DW-1:0] IData_out,
    output logic          IAck,
    output logic          IReady,
    input  logic          DStrobe,
    input  logic          DRW,
    input  logic [AW-1:0] DAddress,
    input  logic [DW-1:0] DData_in,
    output logic [DW-1:0] DData_out,
    output logic          DAck,
    output logic          DReady,
    output logic          MStrobe,
    output logic          MRW,
    output logic [AW-1:0] MAddress,
    output logic [DW-1:0] MData_in,
    input  logic [DW-1:0] MData_out,
    input  logic          MAck,
    input  logic          MReady,
    output logic          IGrant,
    output logic          DGrant
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_I   = 2'd1,
        OWN_D   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_nextState;
    logic   r_iGrant;
    logic   r_dGrant;
    logic   w_tieToD;

`ifdef SYS_ARB_ROUND_ROBIN_EN
    // 0 = icache finished last, 1 = dcache finished last
    logic r_lastGrantD;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_lastGrantD <= 1'b0;
        end else if (r_state == OWN_I && MReady) begin
            r_lastGrantD <= 1'b0;
        end else if (r_state == OWN_D && MReady) begin
            r_lastGrantD <= 1'b1;
        end
    end

    assign w_tieToD = ~r_lastGrantD;
`else
    assign w_tieToD = 1'b1;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_iGrant <= 1'b0;
            r_dGrant <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_iGrant <= (w_nextState == OWN_I);
            r_dGrant <= (w_nextState == OWN_D);
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (IStrobe && DStrobe) begin
                    w_nextState = w_tieToD ? OWN_D : OWN_I;
                end else if (DStrobe) begin
                    w_nextState = OWN_D;
                end else if (IStrobe) begin
                    w_nextState = OWN_I;
                end
            end
            OWN_I:   if (MReady) w_nextState = RELEASE;
            OWN_D:   if (MReady) w_nextState = RELEASE;
            RELEASE: w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Forwarding mux decodes only the registered state, so a strobe never reaches the other master.
    always_comb begin
        MStrobe   = 1'b0;
        MRW       = 1'b1;
        MAddress  = '0;
        MData_in  = '0;
        IAck      = 1'b0;
        IReady    = 1'b0;
        IData_out = '0;
        DAck      = 1'b0;
        DReady    = 1'b0;
        DData_out = '0;
        case (r_state)
            OWN_I: begin
                MStrobe   = IStrobe;
                MAddress  = IAddress;
                IAck      = MAck;
                IReady    = MReady;
                IData_out = MData_out;
            end
            OWN_D: begin
                MStrobe   = DStrobe;
                MRW       = DRW;
                MAddress  = DAddress;
                MData_in  = DData_in;
                DAck      = MAck;
                DReady    = MReady;
                DData_out = MData_out;
            end
            default: ;
        endcase
    end

    assign IGrant = r_iGrant;
    assign DGrant = r_dGrant;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Directed testbench for sys_bus_arbiter; expectations follow SYS_ARB_ROUND_ROBIN_EN when defined.
module tb_sys_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clock;
    logic          reset;
    logic          IStrobe;
    logic [AW-1:0] IAddress;
    logic [DW-1:0] IData_out;
    logic          IAck;
    logic          IReady;
    logic          DStrobe;
    logic          DRW;
    logic [AW-1:0] DAddress;
    logic [DW-1:0] DData_in;
    logic [DW-1:0] DData_out;
    logic          DAck;
    logic          DReady;
    logic          MStrobe;
    logic          MRW;
    logic [AW-1:0] MAddress;
    logic [DW-1:0] MData_in;
    logic [DW-1:0] MData_out;
    logic          MAck;
    logic          MReady;
    logic          IGrant;
    logic          DGrant;

    int total = 0;
    int bad   = 0;

    // {IGrant, DGrant, MStrobe, MRW, IAck, IReady, DAck, DReady}
    logic [7:0] ctl;
    assign ctl = {IGrant, DGrant, MStrobe, MRW, IAck, IReady, DAck, DReady};

    sys_bus_arbiter #(.AW(AW), .DW(DW)) dut (
        .clock(clock), .reset(reset),
        .IStrobe(IStrobe), .IAddress(IAddress), .IData_out(IData_out), .IAck(IAck), .IReady(IReady),
        .DStrobe(DStrobe), .DRW(DRW), .DAddress(DAddress), .DData_in(DData_in),
        .DData_out(DData_out), .DAck(DAck), .DReady(DReady),
        .MStrobe(MStrobe), .MRW(MRW), .MAddress(MAddress), .MData_in(MData_in),
        .MData_out(MData_out), .MAck(MAck), .MReady(MReady),
        .IGrant(IGrant), .DGrant(DGrant)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        IStrobe = 1'b0; IAddress = '0;
        DStrobe = 1'b0; DRW = 1'b0; DAddress = '0; DData_in = '0;
        MData_out = '0; MAck = 1'b0; MReady = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        IStrobe = 1'b1; IAddress = 32'h0000_1234;
        DStrobe = 1'b1; DRW = 1'b0; DAddress = 32'h0000_5678; DData_in = 32'h1111_2222;
        MData_out = 32'h3333_4444; MAck = 1'b1; MReady = 1'b1;
        #2;
        if (ctl !== 8'b0001_0000) begin bad++; $display("[TB] FAIL reset_ctl got=%b exp=%b", ctl, 8'b0001_0000); end
        total++;
        tick();
        if (MAddress !== 32'h0 || MData_in !== 32'h0) begin
            bad++; $display("[TB] FAIL reset_mbus got addr=%h data=%h exp 0", MAddress, MData_in);
        end
        total++;
        if (IData_out !== 32'h0 || DData_out !== 32'h0) begin
            bad++; $display("[TB] FAIL reset_rdata got i=%h d=%h exp 0", IData_out, DData_out);
        end
        total++;
        if (ctl !== 8'b0001_0000) begin bad++; $display("[TB] FAIL reset_held got=%b exp=%b", ctl, 8'b0001_0000); end
        total++;
        reset = 1'b0;
    endtask

    task automatic test_icache_fill();
        int ackCount = 0;
        do_reset();
        IStrobe = 1'b1; IAddress = 32'h0000_1040;
        #1;
        if (ctl !== 8'b0001_0000) begin bad++; $display("[TB] FAIL ifill_bubble got=%b exp=%b", ctl, 8'b0001_0000); end
        total++;
        tick();
        if (ctl !== 8'b1011_0000) begin bad++; $display("[TB] FAIL ifill_grant got=%b exp=%b", ctl, 8'b1011_0000); end
        total++;
        if (MAddress !== 32'h0000_1040) begin bad++; $display("[TB] FAIL ifill_addr got=%h exp=%h", MAddress, 32'h0000_1040); end
        total++;
        for (int b = 0; b < 16; b++) begin
            MAck = 1'b1; MData_out = 32'hA000_0000 + b;
            #1;
            if (ctl !== 8'b1011_1000) begin bad++; $display("[TB] FAIL ifill_beat%0d got=%b exp=%b", b, ctl, 8'b1011_1000); end
            total++;
            if (IData_out !== 32'hA000_0000 + b || DData_out !== 32'h0) begin
                bad++; $display("[TB] FAIL ifill_data%0d got i=%h d=%h exp i=%h d=0", b, IData_out, DData_out, 32'hA000_0000 + b);
            end
            total++;
            if (IAck === 1'b1) ackCount++;
            tick();
        end
        MAck = 1'b0; MReady = 1'b1;
        #1;
        if (ctl !== 8'b1011_0100) begin bad++; $display("[TB] FAIL ifill_ready got=%b exp=%b", ctl, 8'b1011_0100); end
        total++;
        tick();
        MReady = 1'b0; IStrobe = 1'b0;
        #1;
        if (ctl !== 8'b0001_0000) begin bad++; $display("[TB] FAIL ifill_release got=%b exp=%b", ctl, 8'b0001_0000); end
        total++;
        if (ackCount !== 16) begin bad++; $display("[TB] FAIL ifill_ackcount got=%0d exp=16", ackCount); end
        total++;
        tick();
        if (ctl !== 8'b0001_0000) begin bad++; $display("[TB] FAIL ifill_idle got=%b exp=%b", ctl, 8'b0001_0000); end
        total++;
    endtask

    task automatic test_dcache_store();
        do_reset();
        DStrobe = 1'b1; DRW = 1'b0; DAddress = 32'h0000_2004; DData_in = 32'hDEAD_BEEF;
        tick();
        #1;
        if (ctl !== 8'b0110_0000) begin bad++; $display("[TB] FAIL store_grant got=%b exp=%b", ctl, 8'b0110_0000); end
        total++;
        if (MAddress !== 32'h0000_2004 || MData_in !== 32'hDEAD_BEEF) begin
            bad++; $display("[TB] FAIL store_bus got addr=%h data=%h exp addr=00002004 data=deadbeef", MAddress, MData_in);
        end
        total++;
        MAck = 1'b1; MReady = 1'b1;
        #1;
        if (ctl !== 8'b0110_0011) begin bad++; $display("[TB] FAIL store_ackready got=%b exp=%b", ctl, 8'b0110_0011); end
        total++;
        tick();
        MAck = 1'b0; MReady = 1'b0; DStrobe = 1'b0;
        #1;
        if (ctl !== 8'b0001_0000 || MData_in !== 32'h0) begin
            bad++; $display("[TB] FAIL store_release got=%b data=%h exp=%b data=0", ctl, MData_in, 8'b0001_0000);
        end
        total++;
        tick();
        if (ctl !== 8'b0001_0000) begin bad++; $display("[TB] FAIL store_idle got=%b exp=%b", ctl, 8'b0001_0000); end
        total++;
    endtask

    task automatic test_tie();
        logic expectD;
        logic [7:0] expOwn;
        logic [7:0] expDone;
        do_reset();
        IStrobe = 1'b1; IAddress = 32'h0000_0100;
        DStrobe = 1'b1; DRW = 1'b1; DAddress = 32'h0000_0200;
        for (int k = 0; k < 4; k++) begin
`ifdef SYS_ARB_ROUND_ROBIN_EN
            expectD = (k % 2 == 0);
`else
            expectD = 1'b1;
`endif
            expOwn  = expectD ? 8'b0111_0000 : 8'b1011_0000;
            expDone = expectD ? 8'b0111_0011 : 8'b1011_1100;
            tick();
            if (ctl !== expOwn) begin bad++; $display("[TB] FAIL tie%0d_grant got=%b exp=%b", k, ctl, expOwn); end
            total++;
            MAck = 1'b1; MReady = 1'b1;
            #1;
            if (ctl !== expDone) begin bad++; $display("[TB] FAIL tie%0d_done got=%b exp=%b", k, ctl, expDone); end
            total++;
            tick();
            MAck = 1'b0; MReady = 1'b0;
            if (k == 3) DStrobe = 1'b0;
            #1;
            if (ctl !== 8'b0001_0000) begin bad++; $display("[TB] FAIL tie%0d_release got=%b exp=%b", k, ctl, 8'b0001_0000); end
            total++;
            tick();
        end
        tick();
        if (ctl !== 8'b1011_0000) begin bad++; $display("[TB] FAIL tie_ionly got=%b exp=%b", ctl, 8'b1011_0000); end
        total++;
        MAck = 1'b1; MReady = 1'b1;
        tick();
        MAck = 1'b0; MReady = 1'b0; IStrobe = 1'b0;
        tick();
    endtask

    task automatic test_mid_fill();
        do_reset();
        IStrobe = 1'b1; IAddress = 32'h0000_1080;
        tick();
        for (int b = 0; b < 16; b++) begin
            if (b == 5) begin
                DStrobe = 1'b1; DRW = 1'b1; DAddress = 32'h0000_3000;
            end
            MAck = 1'b1; MData_out = b;
            #1;
            if (ctl !== 8'b1011_1000 || DData_out !== 32'h0) begin
                bad++; $display("[TB] FAIL mid_beat%0d got=%b d=%h exp=%b d=0", b, ctl, DData_out, 8'b1011_1000);
            end
            total++;
            tick();
        end
        MAck = 1'b0; MReady = 1'b1;
        #1;
        if (ctl !== 8'b1011_0100) begin bad++; $display("[TB] FAIL mid_iready got=%b exp=%b", ctl, 8'b1011_0100); end
        total++;
        tick();
        MReady = 1'b0; IStrobe = 1'b0;
        #1;
        if (ctl !== 8'b0001_0000) begin bad++; $display("[TB] FAIL mid_release got=%b exp=%b", ctl, 8'b0001_0000); end
        total++;
        tick();
        if (ctl !== 8'b0001_0000) begin bad++; $display("[TB] FAIL mid_idle got=%b exp=%b", ctl, 8'b0001_0000); end
        total++;
        tick();
        if (ctl !== 8'b0111_0000 || MAddress !== 32'h0000_3000) begin
            bad++; $display("[TB] FAIL mid_dgrant got=%b addr=%h exp=%b addr=00003000", ctl, MAddress, 8'b0111_0000);
        end
        total++;
        MAck = 1'b1; MReady = 1'b1; MData_out = 32'h0000_55AA;
        #1;
        if (ctl !== 8'b0111_0011 || DData_out !== 32'h0000_55AA || IData_out !== 32'h0) begin
            bad++; $display("[TB] FAIL mid_dread got=%b d=%h i=%h exp=%b d=000055aa i=0", ctl, DData_out, IData_out, 8'b0111_0011);
        end
        total++;
        tick();
        MAck = 1'b0; MReady = 1'b0; DStrobe = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        IStrobe = 1'b1; IAddress = 32'h0000_1100;
        tick();
        for (int b = 0; b < 5; b++) begin
            MAck = 1'b1;
            tick();
        end
        MAck = 1'b1;
        #1;
        if (ctl !== 8'b1011_1000) begin bad++; $display("[TB] FAIL arst_pre got=%b exp=%b", ctl, 8'b1011_1000); end
        total++;
        #1 reset = 1'b1;
        #1;
        if (ctl !== 8'b0001_0000) begin bad++; $display("[TB] FAIL arst_drop got=%b exp=%b", ctl, 8'b0001_0000); end
        total++;
        #1;
        reset = 1'b0; MAck = 1'b0; IStrobe = 1'b0;
        DStrobe = 1'b1; DRW = 1'b0; DAddress = 32'h0000_4000; DData_in = 32'h0000_1234;
        #1;
        if (ctl !== 8'b0001_0000) begin bad++; $display("[TB] FAIL arst_idle got=%b exp=%b", ctl, 8'b0001_0000); end
        total++;
        tick();
        if (ctl !== 8'b0110_0000 || MData_in !== 32'h0000_1234) begin
            bad++; $display("[TB] FAIL arst_dgrant got=%b data=%h exp=%b data=00001234", ctl, MData_in, 8'b0110_0000);
        end
        total++;
        MAck = 1'b1; MReady = 1'b1;
        #1;
        if (ctl !== 8'b0110_0011) begin bad++; $display("[TB] FAIL arst_ddone got=%b exp=%b", ctl, 8'b0110_0011); end
        total++;
        tick();
        MAck = 1'b0; MReady = 1'b0; DStrobe = 1'b0;
        tick();
    endtask

    task automatic test_stray();
        do_reset();
        MAck = 1'b1; MReady = 1'b1; MData_out = 32'hFFFF_FFFF;
        #1;
        if (ctl !== 8'b0001_0000 || IData_out !== 32'h0 || DData_out !== 32'h0) begin
            bad++; $display("[TB] FAIL stray_idle got=%b i=%h d=%h exp=%b i=0 d=0", ctl, IData_out, DData_out, 8'b0001_0000);
        end
        total++;
        tick();
        if (ctl !== 8'b0001_0000) begin bad++; $display("[TB] FAIL stray_stay got=%b exp=%b", ctl, 8'b0001_0000); end
        total++;
        MAck = 1'b0; MReady = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        test_reset();
        test_icache_fill();
        test_dcache_store();
        test_tie();
        test_mid_fill();
        test_async_reset();
        test_stray();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
